// File: rtl/mem_arbiter_rr.sv
// Multi-port memory arbiter: one transaction at a time, round-robin or fixed priority.
// Requests are arbitrated in IDLE, the winner owns the memory until mem_ack, then a one-cycle DONE.
module mem_arbiter_rr #(
  parameter int unsigned NPORTS  = 3,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 128,
  parameter int unsigned RR_MODE = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NPORTS-1:0]          req,
  input  logic [NPORTS-1:0]          req_rw,
  input  logic [NPORTS*ADDR_W-1:0]   req_addr,
  input  logic [NPORTS*DATA_W-1:0]   req_wdata,
  output logic [NPORTS-1:0]          ack,
  output logic [DATA_W-1:0]          rdata,
  output logic [NPORTS-1:0]          grant,
  output logic                       busy,
  output logic                       mem_enable,
  output logic                       mem_rw,
  input  logic                       mem_ack,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_data_in,
  input  logic [DATA_W-1:0]          mem_data_out
);

  localparam int unsigned IDX_W = (NPORTS > 1) ? $clog2(NPORTS) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              r_state,        w_state;
  logic [IDX_W-1:0]    r_last_grant,   w_last_grant;
  logic [NPORTS-1:0]   r_grant,        w_grant;
  logic [NPORTS-1:0]   r_ack,          w_ack;
  logic [DATA_W-1:0]   r_rdata,        w_rdata;
  logic                r_busy,         w_busy;
  logic                r_mem_enable,   w_mem_enable;
  logic                r_mem_rw,       w_mem_rw;
  logic [ADDR_W-1:0]   r_mem_addr,     w_mem_addr;
  logic [DATA_W-1:0]   r_mem_data_in,  w_mem_data_in;

  logic [IDX_W-1:0]    w_win;
  logic                w_any;

  // First requester scanning upward from the port after the last owner.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NPORTS-1:0] r,
                                               input logic [IDX_W-1:0]  last);
    logic [IDX_W-1:0] pick;
    logic             found;
    int unsigned      c;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= int'(NPORTS); k++) begin
      c = (32'(last) + 32'(k)) % NPORTS;
      if (!found && r[IDX_W'(c)]) begin
        found = 1'b1;
        pick  = IDX_W'(c);
      end
    end
    return pick;
  endfunction

  function automatic logic [IDX_W-1:0] fixed_pick(input logic [NPORTS-1:0] r);
    logic [IDX_W-1:0] pick;
    pick = '0;
    for (int k = int'(NPORTS) - 1; k >= 0; k--) begin
      if (r[IDX_W'(k)]) pick = IDX_W'(k);
    end
    return pick;
  endfunction

  always_comb begin
    w_any = |req;
    w_win = (RR_MODE != 0) ? rr_pick(req, r_last_grant) : fixed_pick(req);
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state       = r_state;
    w_last_grant  = r_last_grant;
    w_grant       = r_grant;
    w_ack         = '0;
    w_rdata       = r_rdata;
    w_mem_enable  = r_mem_enable;
    w_mem_rw      = r_mem_rw;
    w_mem_addr    = r_mem_addr;
    w_mem_data_in = r_mem_data_in;

    unique case (r_state)
      IDLE: begin
        w_grant      = '0;
        w_mem_enable = 1'b0;
        if (w_any) begin
          w_state       = BUSY;
          w_last_grant  = w_win;
          w_grant       = NPORTS'(1) << w_win;
          w_mem_enable  = 1'b1;
          w_mem_rw      = req_rw[w_win];
          w_mem_addr    = req_addr[int'(w_win)*ADDR_W +: ADDR_W];
          w_mem_data_in = req_wdata[int'(w_win)*DATA_W +: DATA_W];
        end
      end
      BUSY: begin
        if (mem_ack) begin
          w_state      = DONE;
          w_mem_enable = 1'b0;
          w_ack        = r_grant;
          if (!r_mem_rw) w_rdata = mem_data_out;
        end
      end
      DONE: begin
        w_state = IDLE;
        w_grant = '0;
      end
      default: begin
        w_state      = IDLE;
        w_grant      = '0;
        w_mem_enable = 1'b0;
      end
    endcase

    w_busy = (w_state != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_last_grant  <= IDX_W'(NPORTS - 1);
      r_grant       <= '0;
      r_ack         <= '0;
      r_rdata       <= '0;
      r_busy        <= 1'b0;
      r_mem_enable  <= 1'b0;
      r_mem_rw      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_data_in <= '0;
    end else begin
      r_state       <= w_state;
      r_last_grant  <= w_last_grant;
      r_grant       <= w_grant;
      r_ack         <= w_ack;
      r_rdata       <= w_rdata;
      r_busy        <= w_busy;
      r_mem_enable  <= w_mem_enable;
      r_mem_rw      <= w_mem_rw;
      r_mem_addr    <= w_mem_addr;
      r_mem_data_in <= w_mem_data_in;
    end
  end

  assign ack         = r_ack;
  assign rdata       = r_rdata;
  assign grant       = r_grant;
  assign busy        = r_busy;
  assign mem_enable  = r_mem_enable;
  assign mem_rw      = r_mem_rw;
  assign mem_addr    = r_mem_addr;
  assign mem_data_in = r_mem_data_in;

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Directed bench for mem_arbiter_rr: a round-robin and a fixed-priority instance share all inputs.
module tb_mem_arbiter_rr;

  localparam int unsigned NP = 3;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 128;

  logic              clk = 1'b0;
  logic              reset;
  logic [NP-1:0]     req;
  logic [NP-1:0]     req_rw;
  logic [NP*AW-1:0]  req_addr;
  logic [NP*DW-1:0]  req_wdata;
  logic              mem_ack;
  logic [DW-1:0]     mem_data_out;

  logic [NP-1:0]     ack, grant, f_ack, f_grant;
  logic [DW-1:0]     rdata, mem_data_in, f_rdata, f_mem_data_in;
  logic [AW-1:0]     mem_addr, f_mem_addr;
  logic              busy, mem_enable, mem_rw, f_busy, f_mem_enable, f_mem_rw;

  typedef struct {
    int          port;
    int          fport;
    logic        rw;
    logic [31:0] addr;
    logic [127:0] wdata;
  } exp_t;

  exp_t          q[$];
  int            n_checks = 0;
  int            n_fails  = 0;
  logic [127:0]  exp_rdata = '0;

  always #5 clk = ~clk;

  mem_arbiter_rr #(.NPORTS(NP), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(1)) u_rr (
    .clk(clk), .reset(reset), .req(req), .req_rw(req_rw), .req_addr(req_addr),
    .req_wdata(req_wdata), .ack(ack), .rdata(rdata), .grant(grant), .busy(busy),
    .mem_enable(mem_enable), .mem_rw(mem_rw), .mem_ack(mem_ack), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  mem_arbiter_rr #(.NPORTS(NP), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(0)) u_fx (
    .clk(clk), .reset(reset), .req(req), .req_rw(req_rw), .req_addr(req_addr),
    .req_wdata(req_wdata), .ack(f_ack), .rdata(f_rdata), .grant(f_grant), .busy(f_busy),
    .mem_enable(f_mem_enable), .mem_rw(f_mem_rw), .mem_ack(mem_ack), .mem_addr(f_mem_addr),
    .mem_data_in(f_mem_data_in), .mem_data_out(mem_data_out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_port(input int p, input logic rw, input logic [31:0] a, input logic [127:0] d);
    req_rw[p]            = rw;
    req_addr[p*AW +: AW] = a;
    req_wdata[p*DW +: DW] = d;
  endtask

  // Memory side: waits for the request, checks it against the scoreboard, answers after lat cycles.
  task automatic run_txn(input int lat, input logic [127:0] mdata, input logic [NP-1:0] next_req);
    exp_t e;
    int   waited;
    logic [NP-1:0] eg, efg;
    waited = 0;
    while (!mem_enable && waited < 20) begin
      tick();
      waited++;
    end
    if (!mem_enable) begin
      chk("mem_enable_timeout", 128'(mem_enable), 128'(1));
      return;
    end
    e   = q.pop_front();
    eg  = NP'(1) << e.port;
    efg = NP'(1) << e.fport;
    chk("grant",        128'(grant), 128'(eg));
    chk("f_grant",      128'(f_grant), 128'(efg));
    chk("busy",         128'(busy), 128'(1));
    chk("mem_addr",     128'(mem_addr), 128'(e.addr));
    chk("mem_rw",       128'(mem_rw), 128'(e.rw));
    if (e.rw) chk("mem_data_in", mem_data_in, e.wdata);
    req = next_req;
    repeat (lat) tick();
    chk("hold_enable",  128'(mem_enable), 128'(1));
    chk("hold_grant",   128'(grant), 128'(eg));
    chk("hold_addr",    128'(mem_addr), 128'(e.addr));
    chk("ack_early",    128'(ack), 128'(0));
    mem_ack      = 1'b1;
    mem_data_out = mdata;
    tick();
    mem_ack = 1'b0;
    if (!e.rw) exp_rdata = mdata;
    chk("ack",          128'(ack), 128'(eg));
    chk("f_ack",        128'(f_ack), 128'(efg));
    chk("done_enable",  128'(mem_enable), 128'(0));
    chk("rdata",        rdata, exp_rdata);
    tick();
    chk("idle_ack",     128'(ack), 128'(0));
    chk("idle_grant",   128'(grant), 128'(0));
    chk("idle_busy",    128'(busy), 128'(0));
  endtask

  initial begin
    reset = 1'b1; req = '0; req_rw = '0; req_addr = '0; req_wdata = '0;
    mem_ack = 1'b0; mem_data_out = '0;
    tick(); tick();
    chk("rst_busy",   128'(busy), 128'(0));
    chk("rst_grant",  128'(grant), 128'(0));
    chk("rst_ack",    128'(ack), 128'(0));
    chk("rst_en",     128'(mem_enable), 128'(0));
    chk("rst_addr",   128'(mem_addr), 128'(0));
    chk("rst_rdata",  rdata, 128'(0));
    reset = 1'b0;
    tick();
    chk("idle_no_req", 128'(mem_enable), 128'(0));

    // Single read from port 0.
    set_port(0, 1'b0, 32'h40, 128'h0);
    req = 3'b001;
    q.push_back('{port: 0, fport: 0, rw: 1'b0, addr: 32'h40, wdata: 128'h0});
    run_txn(4, 128'hA5, 3'b000);

    // Single write from port 2; rdata must keep the last read value.
    set_port(2, 1'b1, 32'h80, 128'h1234);
    req = 3'b100;
    q.push_back('{port: 2, fport: 2, rw: 1'b1, addr: 32'h80, wdata: 128'h1234});
    run_txn(2, 128'hDEAD_BEEF, 3'b000);

    // All ports requesting: round-robin rotates, fixed priority stays on port 0.
    set_port(0, 1'b0, 32'h100, 128'h0);
    set_port(1, 1'b0, 32'h200, 128'h0);
    set_port(2, 1'b0, 32'h300, 128'h0);
    req = 3'b111;
    q.push_back('{port: 0, fport: 0, rw: 1'b0, addr: 32'h100, wdata: 128'h0});
    q.push_back('{port: 1, fport: 0, rw: 1'b0, addr: 32'h200, wdata: 128'h0});
    q.push_back('{port: 2, fport: 0, rw: 1'b0, addr: 32'h300, wdata: 128'h0});
    q.push_back('{port: 0, fport: 0, rw: 1'b0, addr: 32'h100, wdata: 128'h0});
    run_txn(0, 128'h11, 3'b111);
    run_txn(0, 128'h22, 3'b111);
    run_txn(0, 128'h33, 3'b111);
    run_txn(0, 128'h44, 3'b110);

    // Port 0 dropped: both modes move to port 1, which drops its request mid-transaction.
    q.push_back('{port: 1, fport: 1, rw: 1'b0, addr: 32'h200, wdata: 128'h0});
    run_txn(1, 128'h55, 3'b000);

    // Stray mem_ack while idle.
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("stray_busy",  128'(busy), 128'(0));
    chk("stray_ack",   128'(ack), 128'(0));
    chk("stray_en",    128'(mem_enable), 128'(0));
    chk("stray_rdata", rdata, exp_rdata);
    tick();
    chk("stray_idle",  128'(busy), 128'(0));

    // Reset in the middle of a port-1 transaction.
    req = 3'b010;
    tick();
    chk("pre_rst_grant", 128'(grant), 128'(3'b010));
    req = 3'b000;
    #1 reset = 1'b1;
    #2;
    chk("async_grant", 128'(grant), 128'(0));
    chk("async_en",    128'(mem_enable), 128'(0));
    chk("async_busy",  128'(busy), 128'(0));
    chk("async_rdata", rdata, 128'(0));
    mem_ack = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    mem_ack = 1'b0;
    exp_rdata = '0;
    chk("post_rst_ack",  128'(ack), 128'(0));
    chk("post_rst_busy", 128'(busy), 128'(0));
    req = 3'b111;
    q.push_back('{port: 0, fport: 0, rw: 1'b0, addr: 32'h100, wdata: 128'h0});
    run_txn(1, 128'h66, 3'b000);

    chk("queue_empty", 128'(q.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
